// File: rtl/idu_pipe.sv
// Instruction buffer + RV32I decoder: circular FIFO of {inst, pc}; decode is combinational from the head entry.
// Latency 1 from push to out_valid; in_ready depends only on occupancy. Optional macro IDU_PIPE_ILLEGAL_CHECK_EN.
module idu_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [XLEN-1:0]          out_pc,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [4:0]               out_rd,
    output logic [2:0]               out_funct3,
    output logic [XLEN-1:0]          out_imm,
    output logic [7:0]               out_ctrl,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0]     inst_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic            push, pop;

    assign in_ready  = (cnt_q < FULL);
    assign out_valid = (cnt_q != '0);
    assign occupancy = cnt_q;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is never reset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= in_inst;
            pc_mem_q[wr_ptr_q]   <= in_pc;
        end
    end

    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    logic            known, jump, branch, mem_ren, mem_wen, ecall, mret, illegal, rwen;

    assign inst   = inst_mem_q[rd_ptr_q];
    assign opcode = inst[6:0];
    assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s  = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
    assign imm_j  = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        known   = 1'b1;
        jump    = 1'b0;
        branch  = 1'b0;
        mem_ren = 1'b0;
        mem_wen = 1'b0;
        imm     = '0;
        case (opcode)
            OP_LUI, OP_AUIPC:  imm = imm_u;
            OP_JAL:            begin imm = imm_j; jump = 1'b1; end
            OP_JALR:           begin imm = imm_i; jump = 1'b1; end
            OP_BRANCH:         begin imm = imm_b; branch = 1'b1; end
            OP_LOAD:           begin imm = imm_i; mem_ren = 1'b1; end
            OP_STORE:          begin imm = imm_s; mem_wen = 1'b1; end
            OP_IMM, OP_SYSTEM: imm = imm_i;
            OP_OP:             imm = '0;
            default:           known = 1'b0;
        endcase
        ecall = (inst == 32'h0000_0073);
        mret  = (inst == 32'h3020_0073);
`ifdef IDU_PIPE_ILLEGAL_CHECK_EN
        illegal = ~known | (inst == 32'h0);
`else
        illegal = 1'b0;
`endif
        rwen = known & ~illegal & ~mem_wen & ~branch & ~ecall & ~mret & (inst[11:7] != 5'd0);
    end

    always_comb begin
        out_inst   = '0;
        out_pc     = '0;
        out_rs1    = '0;
        out_rs2    = '0;
        out_rd     = '0;
        out_funct3 = '0;
        out_imm    = '0;
        out_ctrl   = '0;
        if (out_valid) begin
            out_inst   = inst;
            out_pc     = pc_mem_q[rd_ptr_q];
            out_rs1    = inst[19:15];
            out_rs2    = inst[24:20];
            out_rd     = inst[11:7];
            out_funct3 = inst[14:12];
            if (known && !illegal) begin
                out_imm  = imm;
                out_ctrl = {1'b0, mret, ecall, jump, branch, mem_ren, mem_wen, rwen};
            end else begin
                out_ctrl = {illegal, 7'b0};
            end
        end
    end
endmodule

// File: tb/tb_idu_pipe.sv
// Randomized scoreboard bench for idu_pipe with directed corner cases; builds with or without IDU_PIPE_ILLEGAL_CHECK_EN.
module tb_idu_pipe;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic            clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     in_inst, out_inst;
    logic [XLEN-1:0] in_pc, out_pc, out_imm;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic [2:0]      out_funct3;
    logic [7:0]      out_ctrl;
    logic [OW-1:0]   occupancy;

    idu_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_imm(out_imm), .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } beat_t;

    typedef struct packed {
        logic [4:0]      rs1, rs2, rd;
        logic [2:0]      f3;
        logic [XLEN-1:0] imm;
        logic [7:0]      ctrl;
    } exp_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;
    bit    seen_rst = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the ISA field definitions using integer arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t e;
        int   s, v;
        bit   known, jmp, br, ld, st, ec, mr, ill, wen;
        logic signed [63:0] wide;
        s = $signed(ins);
        v = 0;
        known = 1;
        jmp = 0; br = 0; ld = 0; st = 0;
        case (ins[6:0])
            7'h37, 7'h17: v = int'(ins & 32'hFFFF_F000);
            7'h6F: begin
                v = (s >>> 31) * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                    + int'(ins[30:21]) * 2;
                jmp = 1;
            end
            7'h67: begin v = s >>> 20; jmp = 1; end
            7'h03: begin v = s >>> 20; ld = 1; end
            7'h13, 7'h73: v = s >>> 20;
            7'h63: begin
                v = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                    + int'(ins[11:8]) * 2;
                br = 1;
            end
            7'h23: begin v = (s >>> 25) * 32 + int'(ins[11:7]); st = 1; end
            7'h33: v = 0;
            default: known = 0;
        endcase
        ec = (ins == 32'h73);
        mr = (ins == 32'h3020_0073);
`ifdef IDU_PIPE_ILLEGAL_CHECK_EN
        ill = !known || ins == 0;
`else
        ill = 0;
`endif
        wide  = v;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.f3  = ins[14:12];
        if (!known || ill) begin
            e.imm  = '0;
            e.ctrl = {ill, 7'b0};
        end else begin
            wen    = !(st || br || ec || mr) && ins[11:7] != 0;
            e.imm  = wide[XLEN-1:0];
            e.ctrl = {1'b0, mr, ec, jmp, br, ld, st, wen};
        end
        return e;
    endfunction

    // Monitor: compares DUT state against the queue model, then advances the model with this cycle's inputs.
    always @(negedge clk) begin
        exp_t e;
        bit   can_push;
        if (seen_rst) begin
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                e = ref_decode(q[0].inst);
                chk("out_inst", 64'(out_inst), 64'(q[0].inst));
                chk("out_pc", 64'(out_pc), 64'(q[0].pc));
                chk("fields", {out_rs1, out_rs2, out_rd, out_funct3}, {e.rs1, e.rs2, e.rd, e.f3});
                chk("out_imm", 64'(out_imm), 64'(e.imm));
                chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
            end else begin
                chk("idle_outputs", {out_ctrl, out_imm, out_rd, out_rs1, out_rs2, out_funct3}, 64'd0);
            end
        end
        if (rst) begin
            q.delete();
            seen_rst = 1;
        end else if (flush) begin
            q.delete();
        end else begin
            can_push = q.size() < DEPTH;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && can_push) q.push_back('{inst: in_inst, pc: in_pc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [10];
        logic [31:0] r;
        int          k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        r = $urandom();
        k = $urandom_range(0, 14);
        if (k < 10)  return {r[31:7], ops[k]};
        if (k == 10) return 32'h0000_0073;
        if (k == 11) return 32'h3020_0073;
        if (k == 12) return 32'h0;
        if (k == 13) return 32'hFFFF_FFFF;
        return r;
    endfunction

    logic [XLEN-1:0] pc_ctr = 32'h8000_0000;

    task automatic drive_beat(input logic [31:0] ins);
        in_valid = 1'b1;
        in_inst  = ins;
        in_pc    = pc_ctr;
        pc_ctr   = pc_ctr + 4;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);

        // addi x1,x0,5
        pc_ctr = 32'h8000_0000;
        drive_beat(32'h0050_0093);
        tick();
        in_valid = 1'b0;
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_rd", 64'(out_rd), 64'd1);
        chk("addi_imm", 64'(out_imm), 64'd5);
        chk("addi_ctrl", 64'(out_ctrl), 64'h01);
        chk("addi_pc", 64'(out_pc), 64'h8000_0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("empty_ctrl", 64'(out_ctrl), 64'd0);

        // beq with imm -8
        drive_beat(32'hFE00_0CE3);
        tick();
        in_valid = 1'b0;
        chk("beq_imm", 64'(out_imm), 64'hFFFF_FFF8);
        chk("beq_ctrl", 64'(out_ctrl), 64'h08);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        drive_beat(32'hFFFF_FFFF);
        tick();
        in_valid = 1'b0;
`ifdef IDU_PIPE_ILLEGAL_CHECK_EN
        chk("allones_ctrl", 64'(out_ctrl), 64'h80);
`else
        chk("allones_ctrl", 64'(out_ctrl), 64'h00);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Fill to capacity, then free one slot
        for (int i = 0; i < DEPTH; i++) begin
            drive_beat(rand_inst());
            tick();
        end
        in_valid = 1'b0;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_occupancy", 64'(occupancy), 64'(DEPTH));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("preflush_occ", 64'(occupancy), 64'd2);

        // Flush with a beat offered in the same cycle
        flush = 1'b1;
        drive_beat(32'h0010_0113);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);

        // Streaming across pointer wrap at constant occupancy
        drive_beat(rand_inst()); tick();
        drive_beat(rand_inst()); tick();
        out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive_beat(rand_inst());
            tick();
            chk("stream_occ", 64'(occupancy), 64'd2);
        end
        in_valid = 1'b0;
        tick(); tick();
        out_ready = 1'b0;

        // Random traffic with occasional flush and reset
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) != 0) drive_beat(rand_inst());
            else in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 300) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        chk("final_empty", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
